// File: rtl/rom_sample_fetch.sv
// Fetch sequencer in front of the five sample/wave ROMs (IC5, IC6, IC7, IC10, IC11).
// Accepts one tagged request at a time, drives the shared ROM address and a one-hot
// chip select, waits WAIT_CYCLES per byte, then returns the byte or little-endian word.
// Optional build macro ROM_FETCH_STATS_EN adds saturating fetch/error counters.
// WAIT_CYCLES legal range is 1..15 (4-bit wait counter).
module rom_sample_fetch #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_chip,
  input  logic [17:0]      req_addr,
  input  logic             req_word,
  input  logic [TAG_W-1:0] req_tag,
  output logic [17:0]      rom_addr,
  output logic [4:0]       rom_cs,
  input  logic [7:0]       rom_d5,
  input  logic [7:0]       rom_d6,
  input  logic [7:0]       rom_d7,
  input  logic [7:0]       rom_d10,
  input  logic [7:0]       rom_d11,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
`ifdef ROM_FETCH_STATS_EN
  ,
  output logic [15:0]      fetch_count,
  output logic [7:0]       err_count
`endif
);

  typedef enum logic [1:0] {StIdle, StAddr0, StAddr1, StResp} state_e;

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       chip_q, chip_d;
  logic             word_q, word_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [15:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [17:0]      rom_addr_q, rom_addr_d;
  logic [4:0]       rom_cs_q, rom_cs_d;
  logic [7:0]       rom_sel;
  logic             capture;
  logic             err_inc;

  // Data mux keyed only by the latched chip index.
  always_comb begin
    rom_sel = 8'h00;
    case (chip_q)
      3'd0:    rom_sel = rom_d5;
      3'd1:    rom_sel = rom_d6;
      3'd2:    rom_sel = rom_d7;
      3'd3:    rom_sel = rom_d10;
      3'd4:    rom_sel = rom_d11;
      default: rom_sel = 8'h00;
    endcase
  end

  // Next-state logic for the fetch FSM and its datapath registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    chip_d     = chip_q;
    word_d     = word_q;
    tag_d      = tag_q;
    data_d     = data_q;
    err_d      = err_q;
    rom_addr_d = rom_addr_q;
    rom_cs_d   = rom_cs_q;
    capture    = 1'b0;
    err_inc    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          chip_d = req_chip;
          word_d = req_word;
          tag_d  = req_tag;
          if (req_chip <= 3'd4) begin
            state_d    = StAddr0;
            rom_addr_d = req_addr;
            rom_cs_d   = 5'b00001 << req_chip;
            cnt_d      = WaitLoad;
            err_d      = 1'b0;
          end else begin
            // Invalid chip: answer immediately, never touch the ROMs.
            state_d  = StResp;
            err_d    = 1'b1;
            data_d   = 16'h0000;
            rom_cs_d = 5'b00000;
            err_inc  = 1'b1;
          end
        end
      end
      StAddr0: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          data_d  = {8'h00, rom_sel};
          if (word_q) begin
            state_d    = StAddr1;
            rom_addr_d = rom_addr_q + 18'd1;  // wraps within the same chip
            cnt_d      = WaitLoad;
          end else begin
            state_d  = StResp;
            rom_cs_d = 5'b00000;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAddr1: begin
        if (cnt_q == 4'd0) begin
          capture      = 1'b1;
          data_d[15:8] = rom_sel;
          state_d      = StResp;
          rom_cs_d     = 5'b00000;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      chip_q     <= 3'd0;
      word_q     <= 1'b0;
      tag_q      <= '0;
      data_q     <= 16'h0000;
      err_q      <= 1'b0;
      rom_addr_q <= 18'd0;
      rom_cs_q   <= 5'b00000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      chip_q     <= chip_d;
      word_q     <= word_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      err_q      <= err_d;
      rom_addr_q <= rom_addr_d;
      rom_cs_q   <= rom_cs_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = data_q;
  assign rsp_tag   = tag_q;
  assign rsp_err   = err_q;
  assign rom_addr  = rom_addr_q;
  assign rom_cs    = rom_cs_q;

`ifdef ROM_FETCH_STATS_EN
  logic [15:0] fetch_count_q;
  logic [7:0]  err_count_q;

  // Saturating counters of ROM byte captures and invalid-chip requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 16'h0000;
      err_count_q   <= 8'h00;
    end else begin
      if (capture && (fetch_count_q != 16'hFFFF)) begin
        fetch_count_q <= fetch_count_q + 16'd1;
      end
      if (err_inc && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign err_count   = err_count_q;
`else
  logic unused_stats;
  assign unused_stats = capture ^ err_inc;
`endif

endmodule

// File: tb/tb_rom_sample_fetch.sv
// Directed bench for rom_sample_fetch (WAIT_CYCLES=2, TAG_W=4).
// ROM model: each chip returns addr[7:0] XOR a per-chip constant, with a few
// fixed locations overridden to the values used in the directed steps.
// Counter checks are compiled in when ROM_FETCH_STATS_EN is defined.
module tb_rom_sample_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_chip;
  logic [17:0] req_addr;
  logic        req_word;
  logic [3:0]  req_tag;
  logic [17:0] rom_addr;
  logic [4:0]  rom_cs;
  logic [7:0]  rom_d5, rom_d6, rom_d7, rom_d10, rom_d11;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
`ifdef ROM_FETCH_STATS_EN
  logic [15:0] fetch_count;
  logic [7:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_d5  = (rom_addr == 18'h3FFFF) ? 8'h12 :
                   (rom_addr == 18'h00000) ? 8'h34 : (rom_addr[7:0] ^ 8'h50);
  assign rom_d6  = rom_addr[7:0] ^ 8'h60;
  assign rom_d7  = rom_addr[7:0] ^ 8'h70;
  assign rom_d10 = (rom_addr == 18'h00001) ? 8'hA7 : (rom_addr[7:0] ^ 8'hA0);
  assign rom_d11 = rom_addr[7:0] ^ 8'hB0;

  rom_sample_fetch #(
    .WAIT_CYCLES(2),
    .TAG_W      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_chip   (req_chip),
    .req_addr   (req_addr),
    .req_word   (req_word),
    .req_tag    (req_tag),
    .rom_addr   (rom_addr),
    .rom_cs     (rom_cs),
    .rom_d5     (rom_d5),
    .rom_d6     (rom_d6),
    .rom_d7     (rom_d7),
    .rom_d10    (rom_d10),
    .rom_d11    (rom_d11),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err)
`ifdef ROM_FETCH_STATS_EN
    ,
    .fetch_count(fetch_count),
    .err_count  (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic [2:0] chip, input logic [17:0] addr, input logic word,
                       input logic [3:0] tag);
    req_chip  = chip;
    req_addr  = addr;
    req_word  = word;
    req_tag   = tag;
    req_valid = 1'b1;
    chk("issue_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0;
  endtask

  // Issue, wait (bounded) for the response, and complete the handshake.
  task automatic run_fetch(input logic [2:0] chip, input logic [17:0] addr, input logic word,
                           input logic [3:0] tag);
    issue(chip, addr, word, tag);
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    chk("rsp_wait", 32'(rsp_valid), 32'h1);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_chip  = 3'd0;
    req_addr  = 18'd0;
    req_word  = 1'b0;
    req_tag   = 4'd0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rom_addr",  32'(rom_addr),  32'h0);
    chk("rst_rom_cs",    32'(rom_cs),    32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(rsp_data),  32'h0);
    chk("rst_rsp_tag",   32'(rsp_tag),   32'h0);
    chk("rst_rsp_err",   32'(rsp_err),   32'h0);

    // Byte fetch IC10 addr 1 tag 5: data A7, valid in cycle 3.
    issue(3'd3, 18'h00001, 1'b0, 4'd5);
    chk("b_c1_cs",        32'(rom_cs),    32'h08);
    chk("b_c1_addr",      32'(rom_addr),  32'h1);
    chk("b_c1_valid",     32'(rsp_valid), 32'h0);
    chk("b_c1_req_ready", 32'(req_ready), 32'h0);
    tick();
    chk("b_c2_cs",    32'(rom_cs),    32'h08);
    chk("b_c2_valid", 32'(rsp_valid), 32'h0);
    tick();
    chk("b_c3_valid", 32'(rsp_valid), 32'h1);
    chk("b_c3_data",  32'(rsp_data),  32'h00A7);
    chk("b_c3_tag",   32'(rsp_tag),   32'h5);
    chk("b_c3_err",   32'(rsp_err),   32'h0);
    chk("b_c3_cs",    32'(rom_cs),    32'h0);
    tick();
    chk("b_c4_valid",     32'(rsp_valid), 32'h0);
    chk("b_c4_req_ready", 32'(req_ready), 32'h1);

    // Word fetch IC5 at 3FFFF: address wraps to 0, data {34,12}.
    issue(3'd0, 18'h3FFFF, 1'b1, 4'd2);
    chk("w_c1_addr", 32'(rom_addr), 32'h3FFFF);
    chk("w_c1_cs",   32'(rom_cs),   32'h01);
    tick();
    chk("w_c2_addr", 32'(rom_addr), 32'h3FFFF);
    tick();
    chk("w_c3_addr", 32'(rom_addr), 32'h0);
    chk("w_c3_cs",   32'(rom_cs),   32'h01);
    tick();
    chk("w_c4_addr",  32'(rom_addr),  32'h0);
    chk("w_c4_valid", 32'(rsp_valid), 32'h0);
    tick();
    chk("w_c5_valid", 32'(rsp_valid), 32'h1);
    chk("w_c5_data",  32'(rsp_data),  32'h3412);
    chk("w_c5_tag",   32'(rsp_tag),   32'h2);
    tick();

    // Invalid chip 6 tag 9: immediate error response.
    issue(3'd6, 18'h00100, 1'b0, 4'd9);
    chk("e_c1_valid", 32'(rsp_valid), 32'h1);
    chk("e_c1_err",   32'(rsp_err),   32'h1);
    chk("e_c1_data",  32'(rsp_data),  32'h0);
    chk("e_c1_cs",    32'(rom_cs),    32'h0);
    chk("e_c1_tag",   32'(rsp_tag),   32'h9);
    tick();
    chk("e_c2_valid",     32'(rsp_valid), 32'h0);
    chk("e_c2_req_ready", 32'(req_ready), 32'h1);

    // Backpressure: word fetch IC6 at 123 -> {24^60, 23^60} = 4443.
    rsp_ready = 1'b0;
    issue(3'd1, 18'h00123, 1'b1, 4'd7);
    chk("bp_c1_cs", 32'(rom_cs), 32'h02);
    tick();
    tick();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_valid",     32'(rsp_valid), 32'h1);
      chk("bp_hold_data",      32'(rsp_data),  32'h4443);
      chk("bp_hold_tag",       32'(rsp_tag),   32'h7);
      chk("bp_hold_err",       32'(rsp_err),   32'h0);
      chk("bp_hold_req_ready", 32'(req_ready), 32'h0);
      tick();
    end
    chk("bp_last_valid", 32'(rsp_valid), 32'h1);
    rsp_ready = 1'b1;
    tick();
    chk("bp_after_valid",     32'(rsp_valid), 32'h0);
    chk("bp_after_req_ready", 32'(req_ready), 32'h1);
    // Next request right after the handshake: IC11 byte at 10 -> 10^B0 = A0.
    issue(3'd4, 18'h00010, 1'b0, 4'd3);
    chk("nx_c1_cs", 32'(rom_cs), 32'h10);
    tick();
    tick();
    chk("nx_c3_valid", 32'(rsp_valid), 32'h1);
    chk("nx_c3_data",  32'(rsp_data),  32'h00A0);
    chk("nx_c3_tag",   32'(rsp_tag),   32'h3);
    tick();

    // Reset during the second ADDR0 cycle of a word fetch aborts it.
    issue(3'd2, 18'h00055, 1'b1, 4'd4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_valid",     32'(rsp_valid), 32'h0);
    chk("ab_cs",        32'(rom_cs),    32'h0);
    chk("ab_req_ready", 32'(req_ready), 32'h1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ab_no_rsp", 32'(rsp_valid), 32'h0);
    end

`ifdef ROM_FETCH_STATS_EN
    // Counters: 3 byte + 2 word fetches = 7 captures, 1 invalid request.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("st_rst_fetch", 32'(fetch_count), 32'h0);
    chk("st_rst_err",   32'(err_count),   32'h0);
    run_fetch(3'd0, 18'h00002, 1'b0, 4'd1);
    run_fetch(3'd1, 18'h00003, 1'b1, 4'd2);
    run_fetch(3'd2, 18'h00004, 1'b0, 4'd3);
    run_fetch(3'd7, 18'h00005, 1'b0, 4'd4);
    run_fetch(3'd3, 18'h00006, 1'b1, 4'd5);
    run_fetch(3'd4, 18'h00007, 1'b0, 4'd6);
    chk("st_fetch_count", 32'(fetch_count), 32'd7);
    chk("st_err_count",   32'(err_count),   32'd1);
`else
    // Same traffic without counters still completes every fetch.
    run_fetch(3'd1, 18'h00003, 1'b1, 4'd2);
    chk("tail_data", 32'(rsp_data), 32'h6463);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
